// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard detection unit: shadow-slot layout and
// register-match predicates.
package hazard_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // valid already folds in RegWrite, so a valid slot is a candidate writer
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             memrd;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    function automatic logic is_writer(slot_t s, logic [REG_W-1:0] r);
        return s.valid && (s.rd != REG_ZERO) && (s.rd == r);
    endfunction

    function automatic logic is_load(slot_t s, logic [REG_W-1:0] r);
        return is_writer(s, r) && s.memrd;
    endfunction

endpackage

// File: rtl/hazard_slot_pipe.sv
// Three-slot shadow pipeline (EX, MEM, WB) of in-flight destinations, with a
// whole-pipe hold and bubble insertion at the EX slot.
module hazard_slot_pipe
    import hazard_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  hold_i,
    input  logic  bubble_i,
    input  slot_t id_slot_i,
    output slot_t ex_o,
    output slot_t mem_o,
    output slot_t wb_o
);

    slot_t slot_q [3];
    slot_t slot_d [3];

    always_comb begin
        slot_d[0] = bubble_i ? SLOT_EMPTY : id_slot_i;
        slot_d[1] = slot_q[0];
        slot_d[2] = slot_q[1];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < 3; i++) slot_q[i] <= SLOT_EMPTY;
        end else if (!hold_i) begin
            for (int i = 0; i < 3; i++) slot_q[i] <= slot_d[i];
        end
    end

    assign ex_o  = slot_q[0];
    assign mem_o = slot_q[1];
    assign wb_o  = slot_q[2];

endmodule

// File: rtl/hazard_detect.sv
// Hazard detection for the ID stage: RAW/branch stalls, jump/branch flush and a
// saturating stall counter. HAZARD_FORWARDING_EN selects the forwarding-aware rules.
module hazard_detect
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IDValid_i,
    input  logic [REG_W-1:0] IDRs_i,
    input  logic [REG_W-1:0] IDRt_i,
    input  logic             IDUsesRs_i,
    input  logic             IDUsesRt_i,
    input  logic [REG_W-1:0] IDRd_i,
    input  logic             IDRegWrite_i,
    input  logic             IDMemRd_i,
    input  logic             IDBranch_i,
    input  logic             BranchTaken_i,
    input  logic             IDJump_i,
    input  logic             MemStall_i,
    output logic             NoOp_o,
    output logic             PCWrite_o,
    output logic             IFIDWrite_o,
    output logic             IFFlush_o,
    output logic [CNT_W-1:0] StallCnt_o
);

    slot_t ex_slot, mem_slot, dbg_wb_unused;
    slot_t id_slot;
    logic  rs_hit, rt_hit, hz;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign id_slot = '{valid: IDValid_i & IDRegWrite_i, rd: IDRd_i, memrd: IDMemRd_i};

    hazard_slot_pipe u_slots (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .hold_i    (MemStall_i),
        .bubble_i  (hz),
        .id_slot_i (id_slot),
        .ex_o      (ex_slot),
        .mem_o     (mem_slot),
        .wb_o      (dbg_wb_unused)
    );

`ifdef HAZARD_FORWARDING_EN
    logic br_rs, br_rt;
    // ALU results forward to EX but not to the ID-stage branch compare
    assign rs_hit = is_load(ex_slot, IDRs_i);
    assign rt_hit = is_load(ex_slot, IDRt_i);
    assign br_rs  = is_writer(ex_slot, IDRs_i) | is_load(mem_slot, IDRs_i);
    assign br_rt  = is_writer(ex_slot, IDRt_i) | is_load(mem_slot, IDRt_i);
    assign hz = IDValid_i & ((IDUsesRs_i & rs_hit) | (IDUsesRt_i & rt_hit) |
                             (IDBranch_i & ((IDUsesRs_i & br_rs) | (IDUsesRt_i & br_rt))));
`else
    logic ld_flags_unused;
    assign ld_flags_unused = ex_slot.memrd | mem_slot.memrd;
    assign rs_hit = is_writer(ex_slot, IDRs_i) | is_writer(mem_slot, IDRs_i);
    assign rt_hit = is_writer(ex_slot, IDRt_i) | is_writer(mem_slot, IDRt_i);
    assign hz = IDValid_i & ((IDUsesRs_i & rs_hit) | (IDUsesRt_i & rt_hit));
`endif

    always_comb begin
        NoOp_o      = 1'b0;
        PCWrite_o   = 1'b0;
        IFIDWrite_o = 1'b0;
        IFFlush_o   = 1'b0;
        if (!rst_i) begin
            NoOp_o = 1'b1;
        end else if (MemStall_i) begin
            NoOp_o = 1'b0;
        end else if (hz) begin
            NoOp_o = 1'b1;
        end else begin
            PCWrite_o   = 1'b1;
            IFIDWrite_o = 1'b1;
            IFFlush_o   = IDValid_i & (IDJump_i | (IDBranch_i & BranchTaken_i));
        end
    end

    assign cnt_d = (hz && !MemStall_i && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign StallCnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_detect.sv
// Directed bench for hazard_detect: per-cycle vector table plus reset and
// memory-stall sequences; expectations follow HAZARD_FORWARDING_EN.
module tb_hazard_detect;

`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int CW = 3;
    localparam int CMAX = 7;

    logic clk, rst_i;
    logic IDValid_i, IDUsesRs_i, IDUsesRt_i, IDRegWrite_i, IDMemRd_i;
    logic IDBranch_i, BranchTaken_i, IDJump_i, MemStall_i;
    logic [4:0] IDRs_i, IDRt_i, IDRd_i;
    logic NoOp_o, PCWrite_o, IFIDWrite_o, IFFlush_o;
    logic [CW-1:0] StallCnt_o;

    hazard_detect #(.CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .IDValid_i(IDValid_i), .IDRs_i(IDRs_i), .IDRt_i(IDRt_i),
        .IDUsesRs_i(IDUsesRs_i), .IDUsesRt_i(IDUsesRt_i), .IDRd_i(IDRd_i),
        .IDRegWrite_i(IDRegWrite_i), .IDMemRd_i(IDMemRd_i),
        .IDBranch_i(IDBranch_i), .BranchTaken_i(BranchTaken_i), .IDJump_i(IDJump_i),
        .MemStall_i(MemStall_i),
        .NoOp_o(NoOp_o), .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o),
        .IFFlush_o(IFFlush_o), .StallCnt_o(StallCnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v; logic [4:0] rs; logic [4:0] rt; logic urs; logic urt;
        logic [4:0] rd; logic rw; logic mr; logic br; logic tk; logic jp; logic ms;
        logic nf_noop; logic nf_flush; logic fw_noop; logic fw_flush;
    } vec_t;

    vec_t tbl [30];
    int total = 0;
    int passed = 0;
    int exp_cnt;

    function automatic vec_t mk(int v, int rs, int rt, int urs, int urt, int rd,
                                int rw, int mr, int br, int tk, int jp, int ms,
                                int nfn, int nff, int fwn, int fwf);
        vec_t r;
        r.v = v[0]; r.rs = rs[4:0]; r.rt = rt[4:0]; r.urs = urs[0]; r.urt = urt[0];
        r.rd = rd[4:0]; r.rw = rw[0]; r.mr = mr[0]; r.br = br[0]; r.tk = tk[0];
        r.jp = jp[0]; r.ms = ms[0];
        r.nf_noop = nfn[0]; r.nf_flush = nff[0]; r.fw_noop = fwn[0]; r.fw_flush = fwf[0];
        return r;
    endfunction

    task automatic drive(vec_t r);
        IDValid_i = r.v; IDRs_i = r.rs; IDRt_i = r.rt; IDUsesRs_i = r.urs;
        IDUsesRt_i = r.urt; IDRd_i = r.rd; IDRegWrite_i = r.rw; IDMemRd_i = r.mr;
        IDBranch_i = r.br; BranchTaken_i = r.tk; IDJump_i = r.jp; MemStall_i = r.ms;
    endtask

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else passed++;
    endtask

    vec_t idle, lw2, dep2, dep2_ms, jmp;
    logic e_noop, e_flush;

    initial begin
        clk = 1'b0;
        rst_i = 1'b0;
        idle    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lw2     = mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        dep2    = mk(1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        dep2_ms = dep2; dep2_ms.ms = 1'b1;
        jmp     = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1);
        drive(idle);

        //               v rs rt us ut rd rw mr br tk jp ms  nfN nfF fwN fwF
        tbl[0]  = mk(1, 1, 4, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); // add $2
        tbl[1]  = mk(1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0); // add $3,$2,$4
        tbl[2]  = mk(1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl[3]  = mk(1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = idle; tbl[5] = idle; tbl[6] = idle;
        tbl[7]  = mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); // lw $2
        tbl[8]  = mk(1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        tbl[9]  = mk(1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl[10] = mk(1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[11] = idle; tbl[12] = idle; tbl[13] = idle;
        tbl[14] = mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); // lw $5
        tbl[15] = mk(1, 5, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0); // beq $5,$0 taken
        tbl[16] = mk(1, 5, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0);
        tbl[17] = mk(1, 5, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1);
        tbl[18] = idle;
        tbl[19] = jmp;                                                   // j, empty slots
        tbl[20] = mk(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); // lw $0
        tbl[21] = mk(1, 0, 1, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); // add $3,$0,$1
        tbl[22] = mk(1, 1, 4, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); // add $7
        tbl[23] = mk(1, 7, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0); // beq $7,$1 not taken
        tbl[24] = mk(1, 7, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        tbl[25] = mk(1, 7, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[26] = mk(1, 1, 4, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); // add $8
        tbl[27] = mk(1, 8, 8, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); // $8 fields unused
        tbl[28] = mk(0, 8, 8, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // invalid ID
        tbl[29] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); // j under MemStall

        @(negedge clk); #1;
        chk("reset_noop", NoOp_o, 1);
        chk("reset_pcw", PCWrite_o, 0);
        chk("reset_ifid", IFIDWrite_o, 0);
        chk("reset_flush", IFFlush_o, 0);
        chk("reset_cnt", StallCnt_o, 0);
        @(negedge clk);
        rst_i = 1'b1;

        exp_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            e_noop  = FWD ? tbl[i].fw_noop  : tbl[i].nf_noop;
            e_flush = FWD ? tbl[i].fw_flush : tbl[i].nf_flush;
            chk($sformatf("row%0d_noop", i), NoOp_o, e_noop);
            chk($sformatf("row%0d_flush", i), IFFlush_o, e_flush);
            chk($sformatf("row%0d_pcw", i), PCWrite_o, !tbl[i].ms && !e_noop);
            chk($sformatf("row%0d_ifid", i), IFIDWrite_o, !tbl[i].ms && !e_noop);
            chk($sformatf("row%0d_cnt", i), StallCnt_o, exp_cnt);
            $display("row %0d: noop=%0d flush=%0d pcw=%0d cnt=%0d", i, NoOp_o, IFFlush_o, PCWrite_o, StallCnt_o);
            if (e_noop && !tbl[i].ms && exp_cnt < CMAX) exp_cnt++;
        end
        @(negedge clk);
        drive(idle);
        #1;
        chk("table_cnt_final", StallCnt_o, FWD ? 4 : 7);

        // reset asserted while a load-use stall is pending
        @(negedge clk); drive(lw2);
        @(negedge clk); drive(dep2);
        #1;
        chk("pre_rst_noop", NoOp_o, 1);
        #1;
        rst_i = 1'b0;
        #1;
        chk("rst_mid_noop", NoOp_o, 1);
        chk("rst_mid_pcw", PCWrite_o, 0);
        chk("rst_mid_ifid", IFIDWrite_o, 0);
        chk("rst_mid_cnt", StallCnt_o, 0);
        drive(jmp);
        #1;
        chk("rst_mid_flush", IFFlush_o, 0);
        $display("reset mid-stall: noop=%0d pcw=%0d cnt=%0d", NoOp_o, PCWrite_o, StallCnt_o);
        @(negedge clk); @(negedge clk);
        rst_i = 1'b1;
        drive(dep2);
        #1;
        chk("post_rst_noop", NoOp_o, 0);
        chk("post_rst_pcw", PCWrite_o, 1);
        @(negedge clk); drive(idle);
        #1;
        chk("post_rst_cnt", StallCnt_o, 0);
        $display("after reset: cnt=%0d", StallCnt_o);
        @(negedge clk); @(negedge clk);

        // MemStall freezes a pending load-use stall for three cycles
        @(negedge clk); drive(lw2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drive(dep2_ms);
            #1;
            chk($sformatf("ms%0d_noop", k), NoOp_o, 0);
            chk($sformatf("ms%0d_pcw", k), PCWrite_o, 0);
            chk($sformatf("ms%0d_ifid", k), IFIDWrite_o, 0);
            chk($sformatf("ms%0d_cnt", k), StallCnt_o, 0);
            $display("memstall %0d: noop=%0d pcw=%0d cnt=%0d", k, NoOp_o, PCWrite_o, StallCnt_o);
        end
        @(negedge clk); drive(dep2);
        #1;
        chk("ms_resume_noop", NoOp_o, 1);
        chk("ms_resume_pcw", PCWrite_o, 0);
        @(negedge clk); drive(dep2);
        #1;
        chk("ms_resume_cnt1", StallCnt_o, 1);
        chk("ms_second_noop", NoOp_o, FWD ? 0 : 1);
        @(negedge clk); drive(idle);
        #1;
        chk("ms_final_cnt", StallCnt_o, FWD ? 1 : 2);
        $display("memstall resume: cnt=%0d", StallCnt_o);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
